// File: rtl/serial_encoder_pkg.sv
// Shared definitions for the serial encoder: FSM state encoding and line levels.
package serial_encoder_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } encStateT;

  // Line levels for the framing bits; the line rests low between frames.
  localparam logic LineIdle  = 1'b0;
  localparam logic LineStart = 1'b1;
  localparam logic LineStop  = 1'b0;

endpackage

// File: rtl/serial_encoder_if.sv
// Load handshake and serial-side status signals of the serial encoder.
interface serial_encoder_if #(
  parameter int unsigned DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] parallelIn;
  logic                  loadValid;
  logic                  loadReady;
  logic                  serialOut;
  logic                  busy;
  logic                  done;

  // Word source side.
  modport master (
    output parallelIn,
    output loadValid,
    input  loadReady,
    input  serialOut,
    input  busy,
    input  done
  );

  // Encoder side.
  modport slave (
    input  parallelIn,
    input  loadValid,
    output loadReady,
    output serialOut,
    output busy,
    output done
  );

endinterface

// File: rtl/encoder_bit_timer.sv
// Loadable down-counter with a zero flag; times how long each serial bit is held.
module encoder_bit_timer #(
  parameter int unsigned Width = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             load,
  input  logic [Width-1:0] loadValue,
  output logic             zero
);

  logic [Width-1:0] countQ;

  // Load has priority; otherwise count down and rest at zero.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      countQ <= '0;
    end else if (load) begin
      countQ <= loadValue;
    end else if (countQ != '0) begin
      countQ <= countQ - 1'b1;
    end
  end

  assign zero = (countQ == '0);

endmodule

// File: rtl/serial_encoder.sv
// Parallel-to-serial transmitter: start(1), data MSB-first, optional even parity, stop(0).
module serial_encoder
  import serial_encoder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned PARITY_EN  = 1
) (
  input  logic             clock,
  input  logic             resetN,
  serial_encoder_if.slave  enc
);

  localparam int unsigned CntW   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned TimerW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES + 1) : 1;

  encStateT              stateQ;
  logic [DATA_WIDTH-1:0] shiftQ;
  logic [DATA_WIDTH-1:0] shiftNext;
  logic [CntW-1:0]       bitCountQ;
  logic                  parityQ;
  logic                  serialOutQ;

  logic timerZero;
  logic timerLoad;
  logic lastStopCycle;
  logic loadReady;
  logic accept;

  // Handshake and status decode from the current state and bit timer.
  always_comb begin
    lastStopCycle = (stateQ == StStop) && timerZero;
    loadReady     = (stateQ == StIdle) || lastStopCycle;
    accept        = enc.loadValid && loadReady;
    // Restart the bit timer on every accept and at each bit boundary.
    timerLoad     = accept || ((stateQ != StIdle) && timerZero);
    shiftNext     = shiftQ << 1;
  end

  encoder_bit_timer #(
    .Width (TimerW)
  ) u_bit_timer (
    .clock     (clock),
    .resetN    (resetN),
    .load      (timerLoad),
    .loadValue (TimerW'(BIT_CYCLES - 1)),
    .zero      (timerZero)
  );

  // Frame sequencer; serialOut is registered with the level of the state being entered.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      stateQ     <= StIdle;
      shiftQ     <= '0;
      bitCountQ  <= '0;
      parityQ    <= 1'b0;
      serialOutQ <= LineIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          serialOutQ <= LineIdle;
          if (accept) begin
            stateQ     <= StStart;
            shiftQ     <= enc.parallelIn;
            parityQ    <= ^enc.parallelIn;
            serialOutQ <= LineStart;
          end
        end
        StStart: begin
          if (timerZero) begin
            stateQ     <= StData;
            bitCountQ  <= CntW'(DATA_WIDTH - 1);
            serialOutQ <= shiftQ[DATA_WIDTH-1];
          end
        end
        StData: begin
          if (timerZero) begin
            if (bitCountQ == '0) begin
              if (PARITY_EN != 0) begin
                stateQ     <= StParity;
                serialOutQ <= parityQ;
              end else begin
                stateQ     <= StStop;
                serialOutQ <= LineStop;
              end
            end else begin
              shiftQ     <= shiftNext;
              bitCountQ  <= bitCountQ - 1'b1;
              serialOutQ <= shiftNext[DATA_WIDTH-1];
            end
          end
        end
        StParity: begin
          if (timerZero) begin
            stateQ     <= StStop;
            serialOutQ <= LineStop;
          end
        end
        StStop: begin
          if (timerZero) begin
            // A word accepted in the last stop cycle starts immediately: no idle gap.
            if (accept) begin
              stateQ     <= StStart;
              shiftQ     <= enc.parallelIn;
              parityQ    <= ^enc.parallelIn;
              serialOutQ <= LineStart;
            end else begin
              stateQ     <= StIdle;
              serialOutQ <= LineIdle;
            end
          end
        end
        default: begin
          stateQ     <= StIdle;
          serialOutQ <= LineIdle;
        end
      endcase
    end
  end

  assign enc.loadReady = loadReady;
  assign enc.serialOut = serialOutQ;
  assign enc.busy      = (stateQ != StIdle);
  assign enc.done      = lastStopCycle;

endmodule

// File: tb/tb_serial_encoder.sv
// Directed bench for serial_encoder: three instances (parity/1 cycle, no parity, 4 cycles/bit).
module tb_serial_encoder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rstA, rstB, rstC;
  int   sel;
  logic [7:0] pIn;
  logic       lValid;

  int checks   = 0;
  int failures = 0;

  serial_encoder_if #(.DATA_WIDTH(8)) busA ();
  serial_encoder_if #(.DATA_WIDTH(8)) busB ();
  serial_encoder_if #(.DATA_WIDTH(8)) busC ();

  serial_encoder #(.DATA_WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(1)) dutA (
    .clock  (clock),
    .resetN (rstA),
    .enc    (busA)
  );
  serial_encoder #(.DATA_WIDTH(8), .BIT_CYCLES(1), .PARITY_EN(0)) dutB (
    .clock  (clock),
    .resetN (rstB),
    .enc    (busB)
  );
  serial_encoder #(.DATA_WIDTH(8), .BIT_CYCLES(4), .PARITY_EN(1)) dutC (
    .clock  (clock),
    .resetN (rstC),
    .enc    (busC)
  );

  // Route stimulus to the selected instance; the others see an idle source.
  assign busA.parallelIn = (sel == 0) ? pIn : 8'h00;
  assign busB.parallelIn = (sel == 1) ? pIn : 8'h00;
  assign busC.parallelIn = (sel == 2) ? pIn : 8'h00;
  assign busA.loadValid  = (sel == 0) && lValid;
  assign busB.loadValid  = (sel == 1) && lValid;
  assign busC.loadValid  = (sel == 2) && lValid;

  logic so, bz, dn, rdy;
  always_comb begin
    so = 1'b0; bz = 1'b0; dn = 1'b0; rdy = 1'b0;
    case (sel)
      0: begin so = busA.serialOut; bz = busA.busy; dn = busA.done; rdy = busA.loadReady; end
      1: begin so = busB.serialOut; bz = busB.busy; dn = busB.done; rdy = busB.loadReady; end
      default: begin so = busC.serialOut; bz = busC.busy; dn = busC.done; rdy = busC.loadReady; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    check({tag, ".serialOut"}, {31'd0, so}, 32'd0);
    check({tag, ".busy"}, {31'd0, bz}, 32'd0);
    check({tag, ".done"}, {31'd0, dn}, 32'd0);
    check({tag, ".loadReady"}, {31'd0, rdy}, 32'd1);
  endtask

  // Walk `cycles` clocks of expected line bits; bit p of the stream is bits[nBits-1-p].
  // done/loadReady are expected only in the last cycle of each frame.
  task automatic runFrame(input string tag, input logic [63:0] bits, input int nBits,
                          input int frameBits, input int bitCycles, input int cycles,
                          input int setAt, input logic [7:0] setData, input int dropAt);
    int  frameCycles;
    logic last;
    frameCycles = frameBits * bitCycles;
    for (int i = 0; i < cycles; i++) begin
      last = ((i + 1) % frameCycles) == 0;
      check($sformatf("%s.serialOut[%0d]", tag, i), {31'd0, so},
            {31'd0, bits[nBits - 1 - i / bitCycles]});
      check($sformatf("%s.busy[%0d]", tag, i), {31'd0, bz}, 32'd1);
      check($sformatf("%s.done[%0d]", tag, i), {31'd0, dn}, {31'd0, last});
      check($sformatf("%s.loadReady[%0d]", tag, i), {31'd0, rdy}, {31'd0, last});
      if (i == setAt) begin
        pIn    = setData;
        lValid = 1'b1;
      end
      if (i == dropAt) lValid = 1'b0;
      step();
    end
  endtask

  // Accept one word, then scramble parallelIn to show it is not reused.
  task automatic send(input logic [7:0] data);
    pIn    = data;
    lValid = 1'b1;
    step();
    lValid = 1'b0;
    pIn    = ~data;
  endtask

  initial begin
    sel = 0; pIn = 8'h00; lValid = 1'b0;
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
    #1;
    sel = 0; checkIdle("resetA");
    sel = 2; checkIdle("resetC");
    step(); step();
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    step();

    // 8'hA5 with parity
    sel = 0;
    checkIdle("idleA");
    send(8'hA5);
    runFrame("a5", 64'b11010010100, 11, 11, 1, 11, -1, 8'h00, -1);
    checkIdle("afterA5");

    // 8'h01 with and without parity
    send(8'h01);
    runFrame("01p", 64'b10000000110, 11, 11, 1, 11, -1, 8'h00, -1);
    checkIdle("after01p");
    sel = 1;
    checkIdle("idleB");
    send(8'h01);
    runFrame("01np", 64'b1000000010, 10, 10, 1, 10, -1, 8'h00, -1);
    checkIdle("after01np");

    // Back-to-back FF then 00, loadValid held high
    sel = 0;
    pIn = 8'hFF; lValid = 1'b1;
    step();
    pIn = 8'h00;
    runFrame("b2b", 64'b1111111110010000000000, 22, 11, 1, 22, -1, 8'h00, 11);
    checkIdle("afterB2b");

    // 3C offered during DATA, still valid at the final stop cycle
    send(8'hA5);
    runFrame("ovl", 64'b1101001010010011110000, 22, 11, 1, 22, 3, 8'h3C, 11);
    checkIdle("afterOvl");

    // 3C offered during DATA but withdrawn before the stop bit: never sent
    send(8'hA5);
    runFrame("drop", 64'b11010010100, 11, 11, 1, 11, 3, 8'h3C, 6);
    checkIdle("afterDrop");

    // Four clocks per bit
    sel = 2;
    checkIdle("idleC");
    send(8'hA5);
    runFrame("slow", 64'b11010010100, 11, 11, 4, 44, -1, 8'h00, -1);
    checkIdle("afterSlow");

    // Abort mid data bit 4
    send(8'hA5);
    runFrame("abort", 64'b11010010100, 11, 11, 4, 18, -1, 8'h00, -1);
    #2 rstC = 1'b0;
    #1 checkIdle("inReset");
    step();
    checkIdle("heldReset");
    rstC = 1'b1;
    step();
    checkIdle("afterAbort");
    send(8'h01);
    runFrame("recover", 64'b10000000110, 11, 11, 4, 44, -1, 8'h00, -1);
    checkIdle("afterRecover");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
